// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with any-integer depth, almost-full/empty thresholds,
// occupancy count, flush and sticky error flags. Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ALM_FULL_TH  = DEPTH - 2,
    parameter int unsigned ALM_EMPTY_TH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_wren,
    input  logic [DATA_W-1:0]            i_wrdata,
    input  logic                         i_rden,
    output logic [DATA_W-1:0]            o_rddata,
    output logic                         o_rdvalid,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_alm_full,
    output logic                         o_alm_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    input  logic                         i_clr_err,
    output logic                         o_overflow,
    output logic                         o_underflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             alm_full_q, alm_full_d;
    logic             alm_empty_q, alm_empty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rd_acc, wr_acc;

    // Pointers wrap explicitly at DEPTH-1 so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Accept decisions, next pointers, count, flags and sticky errors.
    always_comb begin
        rd_acc   = 1'b0;
        wr_acc   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q & ~i_clr_err;
        unf_d    = unf_q & ~i_clr_err;

        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_acc = i_rden & ~empty_q;
            wr_acc = i_wren & (~full_q | rd_acc);
            if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // A same-cycle set wins over the clear.
            if (i_wren & full_q & ~rd_acc) ovf_d = 1'b1;
            if (i_rden & empty_q)          unf_d = 1'b1;
        end

        full_d      = (count_d == CNT_W'(DEPTH));
        empty_d     = (count_d == '0);
        alm_full_d  = (count_d >= CNT_W'(ALM_FULL_TH));
        alm_empty_d = (count_d <= CNT_W'(ALM_EMPTY_TH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            alm_full_q  <= alm_full_d;
            alm_empty_q <= alm_empty_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= i_wrdata;
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; forced to zero while empty.
    assign o_rddata  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign o_rdvalid = ~empty_q;
`else
    logic [DATA_W-1:0] rddata_q, rddata_d;
    logic              rdvalid_q, rdvalid_d;

    always_comb begin
        rddata_d  = rddata_q;
        rdvalid_d = rd_acc;
        if (rd_acc) rddata_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            rddata_q  <= rddata_d;
            rdvalid_q <= rdvalid_d;
        end
    end

    assign o_rddata  = rddata_q;
    assign o_rdvalid = rdvalid_q;
`endif

    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_alm_full  = alm_full_q;
    assign o_alm_empty = alm_empty_q;
    assign o_count     = count_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: DEPTH=16 and DEPTH=12 instances against a queue model.
// Compile with FIFO_FWFT_EN defined to check first-word-fall-through mode.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=16 instance signals
    logic       fl16 = 0, we16 = 0, re16 = 0, ce16 = 0;
    logic [7:0] wd16 = 0, rd16;
    logic       rv16, fu16, em16, af16, ae16, ov16, un16;
    logic [4:0] cnt16;

    // DEPTH=12 instance signals
    logic       fl12 = 0, we12 = 0, re12 = 0, ce12 = 0;
    logic [7:0] wd12 = 0, rd12;
    logic       rv12, fu12, em12, af12, ae12, ov12, un12;
    logic [3:0] cnt12;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .ALM_FULL_TH(14), .ALM_EMPTY_TH(2)) u_dut16 (
        .clk(clk), .rst(rst), .i_flush(fl16), .i_wren(we16), .i_wrdata(wd16), .i_rden(re16),
        .o_rddata(rd16), .o_rdvalid(rv16), .o_full(fu16), .o_empty(em16), .o_alm_full(af16),
        .o_alm_empty(ae16), .o_count(cnt16), .i_clr_err(ce16), .o_overflow(ov16), .o_underflow(un16)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(12), .ALM_FULL_TH(10), .ALM_EMPTY_TH(2)) u_dut12 (
        .clk(clk), .rst(rst), .i_flush(fl12), .i_wren(we12), .i_wrdata(wd12), .i_rden(re12),
        .o_rddata(rd12), .o_rdvalid(rv12), .o_full(fu12), .o_empty(em12), .o_alm_full(af12),
        .o_alm_empty(ae12), .o_count(cnt12), .i_clr_err(ce12), .o_overflow(ov12), .o_underflow(un12)
    );

    // Outputs of whichever instance is under test
    logic       sel12 = 0;
    logic [7:0] o_rd;
    logic       o_rv, o_fu, o_em, o_af, o_ae, o_ov, o_un;
    logic [4:0] o_cnt;
    always_comb begin
        o_rd  = sel12 ? rd12 : rd16;
        o_rv  = sel12 ? rv12 : rv16;
        o_fu  = sel12 ? fu12 : fu16;
        o_em  = sel12 ? em12 : em16;
        o_af  = sel12 ? af12 : af16;
        o_ae  = sel12 ? ae12 : ae16;
        o_ov  = sel12 ? ov12 : ov16;
        o_un  = sel12 ? un12 : un16;
        o_cnt = sel12 ? {1'b0, cnt12} : cnt16;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: occupancy is the queue size, flags derive from it.
    logic [7:0] mq [$];
    int         m_depth, m_aft, m_aet;
    logic       m_ovf, m_unf, m_rdvalid;
    logic [7:0] m_rddata;

    task automatic model_reset(input int depth, input int aft, input int aet);
        mq.delete();
        m_depth   = depth;
        m_aft     = aft;
        m_aet     = aet;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        m_rdvalid = 1'b0;
        m_rddata  = 8'h00;
    endtask

    task automatic model_edge(input logic fl, input logic we, input logic [7:0] wd,
                              input logic re, input logic clr);
        int   sz;
        logic ra, wa;
        sz = mq.size();
        if (fl) begin
            mq.delete();
            m_rdvalid = 1'b0;
            if (clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
        end else begin
            ra = re && (sz > 0);
            wa = we && ((sz < m_depth) || ra);
            m_ovf = (we && (sz == m_depth) && !ra) || (m_ovf && !clr);
            m_unf = (re && (sz == 0)) || (m_unf && !clr);
            m_rdvalid = ra;
            if (ra) m_rddata = mq.pop_front();
            if (wa) mq.push_back(wd);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = mq.size();
        check("count",     32'(o_cnt), 32'(sz));
        check("empty",     32'(o_em),  32'(sz == 0));
        check("full",      32'(o_fu),  32'(sz == m_depth));
        check("alm_full",  32'(o_af),  32'(sz >= m_aft));
        check("alm_empty", 32'(o_ae),  32'(sz <= m_aet));
        check("overflow",  32'(o_ov),  32'(m_ovf));
        check("underflow", 32'(o_un),  32'(m_unf));
`ifdef FIFO_FWFT_EN
        check("rdvalid", 32'(o_rv), 32'(sz > 0));
        if (sz > 0) check("rddata_head", 32'(o_rd), 32'(mq[0]));
`else
        check("rdvalid", 32'(o_rv), 32'(m_rdvalid));
        check("rddata",  32'(o_rd), 32'(m_rddata));
`endif
    endtask

    task automatic drive(input logic fl, input logic we, input logic [7:0] wd,
                         input logic re, input logic clr);
        if (sel12) begin
            fl12 = fl; we12 = we; wd12 = wd; re12 = re; ce12 = clr;
            fl16 = 0;  we16 = 0;  wd16 = 0;  re16 = 0;  ce16 = 0;
        end else begin
            fl16 = fl; we16 = we; wd16 = wd; re16 = re; ce16 = clr;
            fl12 = 0;  we12 = 0;  wd12 = 0;  re12 = 0;  ce12 = 0;
        end
    endtask

    // One clock: drive, model the edge, sample 1ns after it.
    task automatic step(input logic fl, input logic we, input logic [7:0] wd,
                        input logic re, input logic clr);
        drive(fl, we, wd, re, clr);
        @(posedge clk);
        model_edge(fl, we, wd, re, clr);
        #1;
        compare_all();
    endtask

    initial begin
        logic       we, re;
        logic [7:0] d;

        model_reset(16, 14, 2);
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        #2 rst = 1'b0;

        // DEPTH=12: random interleaved traffic across pointer wrap, no over/underflow
        sel12 = 1'b1;
        model_reset(12, 10, 2);
        #1 compare_all();
        for (int i = 0; i < 80; i++) begin
            we = ($urandom_range(0, 99) < 60);
            re = ($urandom_range(0, 99) < 45);
            if (mq.size() == 0) re = 1'b0;
            if (mq.size() == 12 && !re) we = 1'b0;
            step(1'b0, we, 8'($urandom), re, 1'b0);
        end
        while (mq.size() > 0) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // DEPTH=16 from here on
        sel12 = 1'b0;
        model_reset(16, 14, 2);
        #1 compare_all();

        // Fill 0x00..0x0F, then one write too many
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 1)  check("alm_empty_at2", 32'(o_ae), 32'd1);
            if (i == 2)  check("alm_empty_at3", 32'(o_ae), 32'd0);
            if (i == 12) check("alm_full_at13", 32'(o_af), 32'd0);
            if (i == 13) check("alm_full_at14", 32'(o_af), 32'd1);
        end
        check("full_at16",  32'(o_fu),  32'd1);
        check("count_at16", 32'(o_cnt), 32'd16);
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_17th",   32'(o_ov),  32'd1);
        check("count_17th", 32'(o_cnt), 32'd16);

        // Drain in order, read once more, clear errors
        for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
            check("fwft_order", 32'(o_rd), 32'(i));
`endif
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
            check("std_order", 32'(o_rd), 32'(i));
`endif
        end
        check("empty_drained", 32'(o_em), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_extra", 32'(o_un), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", 32'(o_ov), 32'd0);
        check("unf_cleared", 32'(o_un), 32'd0);

        // Full with simultaneous write 0xAA and read
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 127)), 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
        check("count_wr_rd_full", 32'(o_cnt), 32'd16);
        check("no_ovf_wr_rd",     32'(o_ov),  32'd0);
        for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
            if (i == 15) check("aa_16th", 32'(o_rd), 32'hAA);
`endif
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
`ifndef FIFO_FWFT_EN
        check("aa_16th", 32'(o_rd), 32'hAA);
`endif

        // Empty with write+read: write taken, underflow raised
        step(1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
        check("unf_empty_wr_rd", 32'(o_un),  32'd1);
        check("count_empty_wr",  32'(o_cnt), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Flush at count 7 with a concurrent write of 0x55
        while (mq.size() < 7) step(1'b0, 1'b1, 8'($urandom_range(0, 63)), 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        check("flush_count", 32'(o_cnt), 32'd0);
        check("flush_empty", 32'(o_em),  32'd1);
        check("flush_ovf",   32'(o_ov),  32'd0);
        check("flush_unf",   32'(o_un),  32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h60 + 8'(i)), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-burst, between edges
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        #2 rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        model_reset(16, 14, 2);
        check("rst_count",     32'(o_cnt), 32'd0);
        check("rst_empty",     32'(o_em),  32'd1);
        check("rst_alm_empty", 32'(o_ae),  32'd1);
        check("rst_full",      32'(o_fu),  32'd0);
        check("rst_alm_full",  32'(o_af),  32'd0);
        check("rst_rdvalid",   32'(o_rv),  32'd0);
        check("rst_rddata",    32'(o_rd),  32'd0);
        check("rst_ovf",       32'(o_ov),  32'd0);
        check("rst_unf",       32'(o_un),  32'd0);
        #1 rst = 1'b0;

        // Re-run the fill; first write visibility depends on read mode
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 0) begin
`ifdef FIFO_FWFT_EN
                check("fwft_first_valid", 32'(o_rv), 32'd1);
                check("fwft_first_data",  32'(o_rd), 32'h00);
`else
                check("std_first_valid",  32'(o_rv), 32'd0);
`endif
            end
        end

        // Free-running random traffic with errors, clears and flushes
        for (int i = 0; i < 400; i++) begin
            d  = 8'($urandom);
            we = ($urandom_range(0, 99) < ((i % 100) < 50 ? 70 : 35));
            re = ($urandom_range(0, 99) < ((i % 100) < 50 ? 35 : 70));
            step(($urandom_range(0, 31) == 0), we, d, re, ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
